pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV32I pipeline. Each cycle it inspects register indices and control bits from the ID, EX, MEM and WB stages. It drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the operand-forwarding selects for the EX stage. It owns a data-memory wait state machine with a timeout, plus stall and flush performance counters.

---
 rtl/rv_pipe_pkg.sv | 22 ++
 rtl/fwd_unit.sv | 30 +++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
//==============================================================================
// Module : rv_pipe_pkg
// Brief  : Shared types and constants for the RV32I pipeline control path.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } pipe_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

`default_nettype wire

// File: rtl/fwd_unit.sv
//==============================================================================
// Module : fwd_unit
// Brief  : Combinational EX operand forwarding select for one source operand.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module fwd_unit (
  input  logic [4:0] i_ex_rs,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_fwd_sel
);
  import rv_pipe_pkg::*;

  // The younger result in MEM shadows WB; x0 is never a forwarding source.
  always_comb begin
    o_fwd_sel = FWD_RF;
    if (i_mem_reg_write && (i_mem_rd != 5'd0) && (i_mem_rd == i_ex_rs)) begin
      o_fwd_sel = FWD_EXMEM;
    end else if (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == i_ex_rs)) begin
      o_fwd_sel = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//==============================================================================
// Module : pipe_ctrl
// Brief  : Hazard, forwarding and data-memory wait controller for the 5-stage
//          RV32I pipeline, with stall/flush performance counters.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import rv_pipe_pkg::*;

  localparam int                  c_WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

  pipe_state_e         r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic w_freeze;
  logic w_lu_hit;
  logic w_redirect;
  logic w_load_use;
  logic w_unused_ex_reg_write;

  // Loads always write a register, so the EX write flag adds nothing here.
  assign w_unused_ex_reg_write = ex_reg_write;

  always_comb begin
    w_freeze = 1'b1;
    case (r_state)
      RUN:      w_freeze = mem_req && !mem_ready;
      MEM_WAIT: w_freeze = !mem_ready;
      default:  w_freeze = 1'b1;
    endcase
  end

  assign w_lu_hit = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  // A frozen EX cannot act on its redirect; it is taken once the freeze lifts.
  assign w_redirect = !w_freeze && ex_redirect;
  assign w_load_use = !w_freeze && !ex_redirect && w_lu_hit;

  assign pc_write     = !w_freeze && !w_load_use;
  assign ifid_write   = !w_freeze && !w_load_use;
  assign idex_write   = !w_freeze;
  assign exmem_write  = !w_freeze;
  assign ifid_flush   = w_redirect;
  assign idex_bubble  = w_redirect || w_load_use;
  assign memwb_bubble = w_freeze;
  assign mem_err      = r_mem_err;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  fwd_unit u_fwd_a (
    .i_ex_rs         (ex_rs1),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .o_fwd_sel       (fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_ex_rs         (ex_rs2),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .o_fwd_sel       (fwd_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_wait_cnt <= '0;
          if (mem_req && !mem_ready) begin
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_state   <= ERROR;
            r_mem_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
          end
        end
        ERROR: begin
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_freeze || w_load_use) && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_redirect && (r_flush_cnt != c_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//==============================================================================
// Module : tb_pipe_ctrl
// Brief  : Scoreboard testbench for pipe_ctrl (MAX_WAIT=4, CNT_W=4).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble, memwb_bubble}
  localparam logic [6:0] C_RUN = 7'b1111_000;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_FRZ = 7'b0000_001;
  localparam logic [6:0] C_RED = 7'b1111_110;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_redirect;
  logic             mem_reg_write, mem_req, mem_ready, wb_reg_write;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             ifid_flush, idex_bubble, memwb_bubble, mem_err;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [11:0]      w_ctl;

  typedef struct {
    string            tag;
    logic [11:0]      ctl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    bit               chk_cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign w_ctl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
                  idex_bubble, memwb_bubble, fwd_a, fwd_b, mem_err};

  pipe_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [11:0] mk(input logic [6:0] en, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic err);
    return {en, fa, fb, err};
  endfunction

  task automatic push_exp(input string tag, input logic [11:0] ctl,
                          input int sc, input int fc, input bit chk_cnt);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.sc = CNT_W'(sc); e.fc = CNT_W'(fc); e.chk_cnt = chk_cnt;
    sb.push_back(e);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_redirect = 0;
    mem_rd = 0; mem_reg_write = 0; mem_req = 0; mem_ready = 0;
    wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle(); reset = 0;
    push_exp("reset_held", mk(C_RUN, 2'b00, 2'b00, 1'b0), 0, 0, 1'b1);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
    checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s stall_cnt actual=%0d required=%0d", e.tag, stall_cnt, e.sc); end
    checks++; if (flush_cnt !== e.fc) begin failures++; $display("FAIL %s flush_cnt actual=%0d required=%0d", e.tag, flush_cnt, e.fc); end
    @(posedge clk); #1; reset = 1;
    push_exp("after_reset", mk(C_RUN, 2'b00, 2'b00, 1'b0), 0, 0, 1'b1);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
    checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s stall_cnt actual=%0d required=%0d", e.tag, stall_cnt, e.sc); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      idle();
      case (s)
        0: begin load_use(5, 5, 1, 0, 0); push_exp("lu_rs1",      mk(C_LU,  2'b00, 2'b00, 1'b0), 0, 0, 1'b1); end
        1: begin                          push_exp("lu_release",  mk(C_RUN, 2'b00, 2'b00, 1'b0), 1, 0, 1'b1); end
        2: begin load_use(0, 0, 1, 0, 0); push_exp("lu_x0",       mk(C_RUN, 2'b00, 2'b00, 1'b0), 1, 0, 1'b1); end
        3: begin load_use(9, 0, 0, 9, 1); push_exp("lu_rs2",      mk(C_LU,  2'b00, 2'b00, 1'b0), 1, 0, 1'b1); end
        4: begin load_use(9, 0, 0, 9, 0); push_exp("lu_rs2_unused", mk(C_RUN, 2'b00, 2'b00, 1'b0), 2, 0, 1'b1); end
        default: begin load_use(9, 9, 1, 0, 0); ex_mem_read = 0;
                       push_exp("lu_not_load", mk(C_RUN, 2'b00, 2'b00, 1'b0), 2, 0, 1'b1); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
      checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s stall_cnt actual=%0d required=%0d", e.tag, stall_cnt, e.sc); end
      checks++; if (flush_cnt !== e.fc) begin failures++; $display("FAIL %s flush_cnt actual=%0d required=%0d", e.tag, flush_cnt, e.fc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_forward();
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs2 = 7;
                 push_exp("fwd_mem_prio", mk(C_RUN, 2'b00, 2'b01, 1'b0), 2, 0, 1'b1); end
        1: begin mem_rd = 7; wb_rd = 7; mem_reg_write = 0; wb_reg_write = 1; ex_rs2 = 7;
                 push_exp("fwd_wb",       mk(C_RUN, 2'b00, 2'b10, 1'b0), 2, 0, 1'b1); end
        2: begin mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1; ex_rs2 = 0;
                 push_exp("fwd_x0",       mk(C_RUN, 2'b00, 2'b00, 1'b0), 2, 0, 1'b1); end
        3: begin ex_rs1 = 3; ex_rs2 = 4; mem_rd = 3; mem_reg_write = 1; wb_rd = 4; wb_reg_write = 1;
                 push_exp("fwd_split",    mk(C_RUN, 2'b01, 2'b10, 1'b0), 2, 0, 1'b1); end
        default: begin ex_rs1 = 12; ex_rs2 = 12; mem_rd = 12; mem_reg_write = 0; wb_rd = 12; wb_reg_write = 1;
                 push_exp("fwd_both_wb",  mk(C_RUN, 2'b10, 2'b10, 1'b0), 2, 0, 1'b1); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
      checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s stall_cnt actual=%0d required=%0d", e.tag, stall_cnt, e.sc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_load_use();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      idle();
      if (s == 0) begin
        load_use(6, 6, 1, 6, 1); ex_redirect = 1;
        push_exp("redir_over_lu", mk(C_RED, 2'b00, 2'b00, 1'b0), 2, 0, 1'b1);
      end else begin
        push_exp("redir_counted", mk(C_RUN, 2'b00, 2'b00, 1'b0), 2, 1, 1'b1);
      end
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
      checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s stall_cnt actual=%0d required=%0d", e.tag, stall_cnt, e.sc); end
      checks++; if (flush_cnt !== e.fc) begin failures++; $display("FAIL %s flush_cnt actual=%0d required=%0d", e.tag, flush_cnt, e.fc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    exp_t e;
    for (int s = 0; s < 7; s++) begin
      idle();
      case (s)
        0: begin mem_req = 1; mem_ready = 1;
                 push_exp("mem_ready_same", mk(C_RUN, 2'b00, 2'b00, 1'b0), 2, 1, 1'b1); end
        1: begin push_exp("mem_stayed_run", mk(C_RUN, 2'b00, 2'b00, 1'b0), 2, 1, 1'b1); end
        2: begin mem_req = 1;
                 push_exp("wait_1",         mk(C_FRZ, 2'b00, 2'b00, 1'b0), 2, 1, 1'b1); end
        3: begin mem_req = 1; ex_redirect = 1;
                 push_exp("wait_2_redir",   mk(C_FRZ, 2'b00, 2'b00, 1'b0), 3, 1, 1'b1); end
        4: begin mem_req = 1; load_use(5, 5, 1, 0, 0);
                 push_exp("wait_3_lu",      mk(C_FRZ, 2'b00, 2'b00, 1'b0), 4, 1, 1'b1); end
        5: begin mem_req = 1; mem_ready = 1; ex_redirect = 1;
                 push_exp("wait_done_redir", mk(C_RED, 2'b00, 2'b00, 1'b0), 5, 1, 1'b1); end
        default: begin
                 push_exp("wait_back_run",  mk(C_RUN, 2'b00, 2'b00, 1'b0), 5, 2, 1'b1); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
      checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s stall_cnt actual=%0d required=%0d", e.tag, stall_cnt, e.sc); end
      checks++; if (flush_cnt !== e.fc) begin failures++; $display("FAIL %s flush_cnt actual=%0d required=%0d", e.tag, flush_cnt, e.fc); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   seen;
    for (int s = 0; s < 4; s++) begin
      idle(); mem_req = 1;
      push_exp("timeout_wait", mk(C_FRZ, 2'b00, 2'b00, 1'b0), 5 + s, 2, 1'b1);
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s%0d ctl actual=%b required=%b", e.tag, s, w_ctl, e.ctl); end
      checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s%0d stall_cnt actual=%0d required=%0d", e.tag, s, stall_cnt, e.sc); end
      @(posedge clk); #1;
    end
    seen = 0;
    for (int i = 0; i < MAX_WAIT + 2 && !seen; i++) begin
      @(negedge clk);
      if (mem_err === 1'b1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL timeout_reach mem_err actual=%b required=1", mem_err); end
    if (seen) begin @(posedge clk); #1; end
    for (int s = 0; s < 2; s++) begin
      idle(); mem_req = 1; mem_ready = 1;
      push_exp("error_stuck", mk(C_FRZ, 2'b00, 2'b00, 1'b1), 0, 0, 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s%0d ctl actual=%b required=%b", e.tag, s, w_ctl, e.ctl); end
      @(posedge clk); #1;
    end
    idle(); reset = 0;
    push_exp("error_reset", mk(C_RUN, 2'b00, 2'b00, 1'b0), 0, 0, 1'b1);
    #1;
    e = sb.pop_front();
    checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
    checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s stall_cnt actual=%0d required=%0d", e.tag, stall_cnt, e.sc); end
    checks++; if (flush_cnt !== e.fc) begin failures++; $display("FAIL %s flush_cnt actual=%0d required=%0d", e.tag, flush_cnt, e.fc); end
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    push_exp("after_err_reset", mk(C_RUN, 2'b00, 2'b00, 1'b0), 0, 0, 1'b1);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s ctl actual=%b required=%b", e.tag, w_ctl, e.ctl); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    pulse_reset();
    for (int s = 0; s < 21; s++) begin
      idle();
      if (s < 20) begin
        ex_redirect = 1;
        push_exp("sat_redirect", mk(C_RED, 2'b00, 2'b00, 1'b0), 0, (s < 15) ? s : 15, 1'b1);
      end else begin
        push_exp("sat_final", mk(C_RUN, 2'b00, 2'b00, 1'b0), 0, 15, 1'b1);
      end
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (w_ctl !== e.ctl) begin failures++; $display("FAIL %s%0d ctl actual=%b required=%b", e.tag, s, w_ctl, e.ctl); end
      checks++; if (stall_cnt !== e.sc) begin failures++; $display("FAIL %s%0d stall_cnt actual=%0d required=%0d", e.tag, s, stall_cnt, e.sc); end
      checks++; if (flush_cnt !== e.fc) begin failures++; $display("FAIL %s%0d flush_cnt actual=%0d required=%0d", e.tag, s, flush_cnt, e.fc); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_redirect_load_use();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
